deserializer_sync: RTL and testbench
====================================

Name: deserializer_sync

Overview:
Receive side of the team's 8-bit SerDes link. The block takes the single-bit stream produced by the serializer, MSB first. It hunts for a fixed sync word to establish word alignment, then reassembles each following group of WIDTH bits into a parallel word, emitted with a one-cycle valid strobe. It sits directly after the serial line, or after a loopback from the serializer, and feeds the parallel receive datapath.

Parameters:
WIDTH, 8, parallel word width in bits (at least 4).
LOG_WIDTH, 3, bit-counter width; equals ceil(log2(WIDTH)).
SYNC_WORD, 8'h7E, alignment pattern; WIDTH bits, MSB received first.

Ports:
clock_in  input  1  single receive clock; all state updates on the rising edge.
reset_n  input  1  asynchronous active-low reset.
din  input  1  serial data bit, MSB of each word first.
din_en  input  1  qualifies din; a bit is consumed only on edges where din_en=1.
resync  input  1  synchronous request to drop lock and re-hunt.
dout  output  WIDTH  last assembled data word; holds until the next word.
dout_valid  output  1  one-cycle pulse, asserted when dout updates.
locked  output  1  high while in LOCKED state.
sync_det  output  1  one-cycle pulse when a sync word is recognised.

Behaviour:
- Reset (async, reset_n=0):
  - shift register=0, bit_cnt=0, state=HUNT.
  - dout=0, dout_valid=0, locked=0, sync_det=0.
  - Deassertion takes effect at the next rising edge.
- Shift register: WIDTH bits. On each edge with din_en=1, sr <= {sr[WIDTH-2:0], din}.
- The "candidate" is the shifted value including the current din. All matches and outputs use the candidate, never the stale sr.
- States: HUNT, LOCKED.
- HUNT:
  - Each enabled edge: if candidate==SYNC_WORD, go to LOCKED, bit_cnt<=0, sync_det=1 for that cycle.
  - Otherwise stay in HUNT. Matching is bit-sliding, with no word boundary assumed.
- LOCKED:
  - Each enabled edge increments bit_cnt.
  - On the edge consuming the WIDTH-th bit (bit_cnt==WIDTH-1), bit_cnt wraps to 0.
  - If the candidate != SYNC_WORD: dout<=candidate and dout_valid=1 for one cycle.
  - If the candidate == SYNC_WORD: no dout update, sync_det=1. Sync words are stripped from the data stream.
  - Output latency: the word is visible on dout, with dout_valid high, in the cycle after the edge that sampled its LSB.
- din_en=0: sr, bit_cnt and state hold. dout_valid and sync_det are 0 in that cycle.
- resync=1 at an edge:
  - state<=HUNT, bit_cnt<=0, locked<=0.
  - The din on that edge is discarded even if din_en=1. resync wins over all other events.
  - sr is cleared to 0 so a partial word cannot produce a false match.
- locked is registered and follows state; it is 1 from the cycle after the matching edge.
- dout_valid and sync_det are never high in the same cycle.
- Reset asserted mid-word: all state is lost immediately and the next word requires a fresh sync.
- bit_cnt is LOG_WIDTH bits, wraps at WIDTH-1. No other counter exists.

Test Plan:
- Reset, then serial 0x7E then 0xA5 (MSB first, din_en=1 every cycle):
  - sync_det pulses after bit 8.
  - locked=1 the next cycle.
  - dout=0xA5 with dout_valid=1 exactly once, one cycle after bit 16.
  - No dout_valid during HUNT.
- Unaligned lock: stream 3 junk bits (101), then 0x7E, 0x3C, 0xF0.
  - Lock is acquired after the sync.
  - dout_valid pulses yield 0x3C then 0xF0, in order, 8 enabled cycles apart.
- Gapped input: same 0x7E, 0x55 stream, with din_en=0 every other cycle.
  - The same words are produced.
  - Valid arrives 8 enabled bits after the sync.
  - Outputs hold during gaps.
- Sync stripping: while locked, send 0x7E, 0x7E, 0x81.
  - Two sync_det pulses, no dout_valid for them.
  - dout=0x81 with a single valid pulse.
- resync mid-word: locked, assert resync after 4 bits of 0xCC, then send 0xCC, 0x7E, 0x33.
  - locked drops next cycle.
  - No word is output until re-sync.
  - Then dout=0x33.
- Async reset mid-word: pull reset_n low between clock edges while locked.
  - dout=0, locked=0, dout_valid=0 immediately, without waiting for a clock edge.
  - After release, data without a sync word produces no dout_valid.

Source files
------------

// File: rtl/deserializer_sync_if.sv
// Serial receive bundle: line side inputs and parallel word side outputs.
// master drives the serial line, slave is the deserializer.
interface deserializer_sync_if #(
  parameter int WIDTH = 8
);
  logic             din;
  logic             din_en;
  logic             resync;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             locked;
  logic             sync_det;

  modport master (
    output din, din_en, resync,
    input  dout, dout_valid, locked, sync_det
  );

  modport slave (
    input  din, din_en, resync,
    output dout, dout_valid, locked, sync_det
  );
endinterface

// File: rtl/deserializer_sync.sv
// SerDes receive side: hunts for the sync word, then assembles MSB-first
// WIDTH-bit words, stripping repeated sync words from the data stream.
module deserializer_sync #(
  parameter int               WIDTH     = 8,
  parameter int               LOG_WIDTH = 3,
  parameter logic [WIDTH-1:0] SYNC_WORD = 8'h7E
) (
  input logic                clock_in,
  input logic                reset_n,
  deserializer_sync_if.slave bus
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     sr_q, sr_d;
  logic [LOG_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     dout_q, dout_d;
  logic                 valid_q, valid_d;
  logic                 sdet_q, sdet_d;
  logic                 locked_q;

  logic [WIDTH-1:0] cand;
  logic             match;
  logic             word_end;

  // Decisions always use the word including the bit on the line now.
  assign cand     = {sr_q[WIDTH-2:0], bus.din};
  assign match    = (cand == SYNC_WORD);
  assign word_end = (cnt_q == LOG_WIDTH'(WIDTH-1));

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= HUNT;
      sr_q     <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      sdet_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      sdet_q   <= sdet_d;
      locked_q <= (state_d == LOCKED);
    end
  end

  always_comb begin
    state_d = state_q;
    priority case (1'b1)
      bus.resync:        state_d = HUNT;
      !bus.din_en:       state_d = state_q;
      state_q == HUNT:   if (match) state_d = LOCKED;
      default:           state_d = LOCKED;
    endcase
  end

  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    sdet_d  = 1'b0;
    priority case (1'b1)
      // Clearing sr keeps a partial word from forming a false match.
      bus.resync: begin
        sr_d  = '0;
        cnt_d = '0;
      end
      !bus.din_en: begin
        sr_d = sr_q;
      end
      state_q == HUNT: begin
        sr_d   = cand;
        cnt_d  = '0;
        sdet_d = match;
      end
      default: begin
        sr_d  = cand;
        cnt_d = word_end ? '0 : cnt_q + LOG_WIDTH'(1);
        if (word_end) begin
          if (match) begin
            sdet_d = 1'b1;
          end else begin
            dout_d  = cand;
            valid_d = 1'b1;
          end
        end
      end
    endcase
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.locked     = locked_q;
  assign bus.sync_det   = sdet_q;

endmodule

// File: tb/tb_deserializer_sync.sv
// Directed bench for deserializer_sync: table of bytes with expected
// outputs, plus hand sequences for alignment, resync and async reset.
module tb_deserializer_sync;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  deserializer_sync_if #(.WIDTH(8)) bus ();

  deserializer_sync #(
    .WIDTH(8),
    .LOG_WIDTH(3),
    .SYNC_WORD(8'h7E)
  ) dut (
    .clock_in(clk),
    .reset_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic       rst;
    logic       gap;
    logic [7:0] data;
    logic       e_valid;
    logic [7:0] e_dout;
    logic       e_locked;
    logic       e_sdet;
  } vec_t;

  vec_t       tbl[9];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] cur_dout;
  logic       cur_locked;

  task automatic chk(input string nm, input logic v, input logic [7:0] d,
                     input logic l, input logic s);
    n_vec++;
    if (bus.dout_valid !== v || bus.dout !== d ||
        bus.locked !== l || bus.sync_det !== s) begin
      n_err++;
      $display("FAIL %s: got valid=%b dout=%h locked=%b sync_det=%b, want valid=%b dout=%h locked=%b sync_det=%b",
               nm, bus.dout_valid, bus.dout, bus.locked, bus.sync_det,
               v, d, l, s);
    end
  endtask

  task automatic step(input logic b, input logic en, input logic rs);
    bus.din    = b;
    bus.din_en = en;
    bus.resync = rs;
    @(posedge clk);
    #1;
    bus.din_en = 1'b0;
    bus.resync = 1'b0;
  endtask

  task automatic send_byte(input string nm, input logic [7:0] b,
                           input logic gap, input logic ev,
                           input logic [7:0] ed, input logic el,
                           input logic es);
    for (int i = 7; i >= 0; i--) begin
      if (gap) begin
        step(1'b1, 1'b0, 1'b0);
        chk({nm, "/gap"}, 1'b0, cur_dout, cur_locked, 1'b0);
      end
      step(b[i], 1'b1, 1'b0);
      if (i != 0) chk({nm, "/bit"}, 1'b0, cur_dout, cur_locked, 1'b0);
    end
    chk(nm, ev, ed, el, es);
    cur_dout   = ed;
    cur_locked = el;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cur_dout   = 8'h00;
    cur_locked = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 1'b0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] junk;
    bus.din    = 1'b0;
    bus.din_en = 1'b0;
    bus.resync = 1'b0;

    tbl[0] = '{1'b1, 1'b0, 8'h7E, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 8'h7E, 1'b0, 8'hA5, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 8'h7E, 1'b0, 8'hA5, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 8'h81, 1'b1, 8'h81, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 8'hF0, 1'b1, 8'hF0, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 8'h7E, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 1'b1, 8'h55, 1'b1, 8'h55, 1'b1, 1'b0};

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].rst) do_reset();
      send_byte($sformatf("vec%0d", i), tbl[i].data, tbl[i].gap,
                tbl[i].e_valid, tbl[i].e_dout, tbl[i].e_locked,
                tbl[i].e_sdet);
    end

    // Unaligned lock: three junk bits before the sync word
    do_reset();
    junk = 8'b0000_0101;
    for (int i = 2; i >= 0; i--) begin
      step(junk[i], 1'b1, 1'b0);
      chk("junk", 1'b0, 8'h00, 1'b0, 1'b0);
    end
    send_byte("unal_sync", 8'h7E, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    send_byte("unal_3c", 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0);
    send_byte("unal_f0", 8'hF0, 1'b0, 1'b1, 8'hF0, 1'b1, 1'b0);

    // resync after four bits of a word while locked
    do_reset();
    send_byte("rs_sync", 8'h7E, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    junk = 8'hCC;
    for (int i = 7; i >= 4; i--) begin
      step(junk[i], 1'b1, 1'b0);
      chk("rs_part", 1'b0, 8'h00, 1'b1, 1'b0);
    end
    step(1'b1, 1'b1, 1'b1);
    cur_locked = 1'b0;
    chk("rs_drop", 1'b0, 8'h00, 1'b0, 1'b0);
    send_byte("rs_cc", 8'hCC, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    send_byte("rs_resync", 8'h7E, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    send_byte("rs_33", 8'h33, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0);

    // Async reset between edges while locked and mid-word
    do_reset();
    send_byte("ar_sync", 8'h7E, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    send_byte("ar_3c", 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0);
    junk = 8'hA5;
    for (int i = 7; i >= 5; i--) begin
      step(junk[i], 1'b1, 1'b0);
      chk("ar_part", 1'b0, 8'h3C, 1'b1, 1'b0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_async", 1'b0, 8'h00, 1'b0, 1'b0);
    cur_dout   = 8'h00;
    cur_locked = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send_byte("ar_nosync1", 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    send_byte("ar_nosync2", 8'h81, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
